pseudo_ana_axes: RTL
====================

// Module: pseudo_ana_axes
// PURPOSE
//  Generalised digital-to-pseudo-analog stick generator: converts NAXES pairs of digital direction inputs
//  (POS/NEG) into W-bit unsigned analog axis values, updated once per frame TICK. Adds acceleration,
//  selectable self-centring/hold mode, clean both-pressed handling and per-axis real-analog passthrough.
//  Sits between hps_io/keyboard decode and the game core's analog inputs (AX*/AY*).
// PARAMETERS
//  NAXES     2    number of independent axes (X/Y per stick -> 2 per player)
//  W         8    output width per axis (unsigned)
//  DELT_MIN  4    first step applied when a direction is pressed
//  DELT_MAX  15   step ceiling while held; also the return-to-centre step
//  ACCEL     1    step increment per TICK while the same direction stays held
//  LIMIT     120  symmetric clamp on internal position, |pos| <= LIMIT
//  CENTER    127  offset added to pos to form the output (2^(W-1)-1)
// PORTS
//  CLK      in   1         system clock (clk_sys)
//  RESET_N  in   1         synchronous reset, active low
//  TICK     in   1         frame strobe level (e.g. VBLANK/PV==0); rising edge = update
//  MODE     in   1         0 = self-centring, 1 = hold position on release
//  POS      in   NAXES     per-axis "increase" direction held
//  NEG      in   NAXES     per-axis "decrease" direction held
//  ANA_SEL  in   NAXES     per-axis 1 = output ANA_IN instead of pseudo value
//  ANA_IN   in   NAXES*W   real analog values, axis i at [i*W +: W]
//  AOUT     out  NAXES*W   registered axis outputs, axis i at [i*W +: W]
//  ACTIVE   out  NAXES     registered, 1 while axis is in DRIVE
// BEHAVIOUR
//  - Reset (RESET_N=0 at CLK edge): pos=0, step=DELT_MIN, state=IDLE, last_dir=none, AOUT=CENTER every axis
//    (regardless of ANA_SEL), ACTIVE=0, tick_d=1 (TICK held high across reset release gives no update).
//  - Edge: tick_d <= TICK each cycle; upd = TICK & ~tick_d. pos/state/step change only in cycles with upd.
//  - Direction per axis sampled only on upd: dir=+1 if POS&~NEG, -1 if NEG&~POS, else 0 (both = none).
//  - pos: signed, W+2 bits; clamp to [-LIMIT,+LIMIT] after every add, in the same cycle.
//  - States per axis, evaluated on upd:
//    IDLE   : pos==0, dir==0. dir!=0 -> DRIVE, pos+=dir*DELT_MIN, step<=DELT_MIN.
//    DRIVE  : dir==last_dir -> step'=min(step+ACCEL,DELT_MAX), pos+=dir*step'.
//             dir==-last_dir (reversal) -> step'=DELT_MIN, pos+=dir*DELT_MIN.
//             dir==0 -> MODE ? HOLD : RETURN (pos unchanged this tick).
//    RETURN : dir!=0 -> as IDLE entry. else |pos|<=DELT_MAX -> pos=0, IDLE; else pos-=sign(pos)*DELT_MAX.
//    HOLD   : dir!=0 -> as IDLE entry. MODE=0 -> RETURN (pos moves from next upd). else pos unchanged.
//    DRIVE entry from IDLE/RETURN/HOLD always restarts step at DELT_MIN; last_dir<=dir on every DRIVE tick.
//  - Output: AOUT[i] <= ANA_SEL[i] ? ANA_IN[i] : (pos_i + CENTER) truncated to W bits; ACTIVE[i] <= (state==DRIVE).
//  - Latency: TICK rises in cycle k -> pos updated end of k -> AOUT valid end of k+1 (2 CLKs).
//    ANA_SEL/ANA_IN -> AOUT: 1 CLK. Axes fully independent; pos keeps tracking while ANA_SEL=1.
//  - Reset mid-ramp: everything returns to reset values on that edge; no residual step.
//  - Parameter legality (elaborate-time): DELT_MIN<=DELT_MAX<=LIMIT, LIMIT+CENTER < 2^W, CENTER>=LIMIT.
// TESTING
//  1 Reset: RESET_N=0 3 cycles with TICK=1, release with TICK still 1 -> AOUT=127 all axes, no update until
//    TICK falls and rises again; ACTIVE=0.
//  2 Ramp: POS[0] held, 5 ticks -> pos 4,9,15,22,30 -> AOUT[0]=131,136,142,149,157, each 2 CLKs after TICK
//    rise; ACTIVE[0]=1; AOUT[1] stays 127.
//  3 Clamp: POS[0] held 20 ticks -> AOUT[0] saturates at 247, never exceeds; NEG held -> floor 7.
//  4 Return (MODE=0): release at pos 120 -> tick1 unchanged (->RETURN), then 105,90,...,15,0 (AOUT 127), IDLE;
//    release at pos 22 -> 7 then 0.
//  5 Hold/reversal (MODE=1): release at 30 -> AOUT stays 157 over 10 ticks; press NEG -> 26 (step restarts 4),
//    then 21; set MODE=0 with no input -> returns to 127.
//  6 POS&NEG both held -> treated as release; ANA_SEL[1]=1, ANA_IN[1]=8'h3C -> AOUT[1]=8'h3C after 1 CLK;
//    NAXES=4, W=10 build: axes 0..3 driven independently with per-axis values correct.

Source files
------------

// File: rtl/pseudo_ana_axes.sv
// Converts per-axis POS/NEG direction pairs into W-bit pseudo-analog axis values, one step per TICK rising edge.
// Latency TICK rise -> AOUT 2 clocks, ANA_SEL/ANA_IN -> AOUT 1 clock; no backpressure (free-running outputs).
module pseudo_ana_axes #(
    parameter int NAXES    = 2,
    parameter int W        = 8,
    parameter int DELT_MIN = 4,
    parameter int DELT_MAX = 15,
    parameter int ACCEL    = 1,
    parameter int LIMIT    = 120,
    parameter int CENTER   = 127
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 tick_i,
    input  logic                 mode_i,
    input  logic [NAXES-1:0]     pos_i,
    input  logic [NAXES-1:0]     neg_i,
    input  logic [NAXES-1:0]     ana_sel_i,
    input  logic [NAXES*W-1:0]   ana_in_i,
    output logic [NAXES*W-1:0]   aout_o,
    output logic [NAXES-1:0]     active_o
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RETURN, S_HOLD} state_t;

    localparam logic signed [W+1:0] LIM    = (W+2)'(LIMIT);
    localparam logic signed [W+1:0] DMAX_S = (W+2)'(DELT_MAX);
    localparam logic [W-1:0]        DMIN   = W'(DELT_MIN);
    localparam logic [W-1:0]        DMAX   = W'(DELT_MAX);
    localparam logic [W:0]          ACC    = (W+1)'(ACCEL);
    localparam logic [W-1:0]        CTR    = W'(CENTER);

    if (!(DELT_MIN <= DELT_MAX && DELT_MAX <= LIMIT && LIMIT + CENTER < (1 << W) && CENTER >= LIMIT))
    begin : g_bad_params
        $error("pseudo_ana_axes: illegal parameter combination");
    end

    state_t                 state_q [NAXES];
    state_t                 state_d [NAXES];
    logic signed [W+1:0]    pos_q   [NAXES];
    logic signed [W+1:0]    pos_d   [NAXES];
    logic [W-1:0]           step_q  [NAXES];
    logic [W-1:0]           step_d  [NAXES];
    logic [1:0]             last_q  [NAXES];
    logic [1:0]             last_d  [NAXES];
    logic [1:0]             dir     [NAXES];
    logic                   tick_q;
    logic                   upd;
    logic [NAXES*W-1:0]     aout_q;
    logic [NAXES*W-1:0]     aout_d;
    logic [NAXES-1:0]       active_q;
    logic [NAXES-1:0]       active_d;

    assign upd      = tick_i & ~tick_q;
    assign aout_o   = aout_q;
    assign active_o = active_q;

    // dir encoding: 2'b01 = increase, 2'b10 = decrease, 2'b00 = none (both pressed counts as none)
    for (genvar g = 0; g < NAXES; g++) begin : g_axis
        assign dir[g]             = {neg_i[g] & ~pos_i[g], pos_i[g] & ~neg_i[g]};
        assign aout_d[g*W +: W]   = ana_sel_i[g] ? ana_in_i[g*W +: W] : pos_q[g][W-1:0] + CTR;
        assign active_d[g]        = (state_q[g] == S_DRIVE);
    end

    function automatic logic [W-1:0] accel(input logic [W-1:0] s);
        logic [W:0] t;
        t = {1'b0, s} + ACC;
        return (t >= {1'b0, DMAX}) ? DMAX : t[W-1:0];
    endfunction

    function automatic logic signed [W+1:0] move(input logic signed [W+1:0] p, input logic up,
                                                 input logic [W-1:0] mag);
        logic signed [W+1:0] m;
        logic signed [W+1:0] v;
        m = $signed({2'b00, mag});
        v = up ? p + m : p - m;
        if (v > LIM)
            return LIM;
        if (v < -LIM)
            return -LIM;
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < NAXES; i++) begin
            state_d[i] = state_q[i];
            pos_d[i]   = pos_q[i];
            step_d[i]  = step_q[i];
            last_d[i]  = last_q[i];
            if (upd) begin
                case (state_q[i])
                    S_DRIVE: begin
                        if (dir[i] == 2'b00) begin
                            state_d[i] = mode_i ? S_HOLD : S_RETURN;
                        end else if (dir[i] == last_q[i]) begin
                            last_d[i] = dir[i];
                            step_d[i] = accel(step_q[i]);
                            pos_d[i]  = move(pos_q[i], dir[i][0], accel(step_q[i]));
                        end else begin
                            last_d[i] = dir[i];
                            step_d[i] = DMIN;
                            pos_d[i]  = move(pos_q[i], dir[i][0], DMIN);
                        end
                    end
                    default: begin
                        // IDLE, RETURN and HOLD all re-enter DRIVE the same way, with a fresh step
                        if (dir[i] != 2'b00) begin
                            state_d[i] = S_DRIVE;
                            last_d[i]  = dir[i];
                            step_d[i]  = DMIN;
                            pos_d[i]   = move(pos_q[i], dir[i][0], DMIN);
                        end else if (state_q[i] == S_RETURN) begin
                            if (pos_q[i] <= DMAX_S && pos_q[i] >= -DMAX_S) begin
                                pos_d[i]   = '0;
                                state_d[i] = S_IDLE;
                            end else begin
                                pos_d[i] = move(pos_q[i], pos_q[i][W+1], DMAX);
                            end
                        end else if (state_q[i] == S_HOLD && !mode_i) begin
                            state_d[i] = S_RETURN;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            tick_q   <= 1'b1;
            aout_q   <= {NAXES{CTR}};
            active_q <= '0;
            for (int i = 0; i < NAXES; i++) begin
                state_q[i] <= S_IDLE;
                pos_q[i]   <= '0;
                step_q[i]  <= DMIN;
                last_q[i]  <= 2'b00;
            end
        end else begin
            tick_q   <= tick_i;
            aout_q   <= aout_d;
            active_q <= active_d;
            for (int i = 0; i < NAXES; i++) begin
                state_q[i] <= state_d[i];
                pos_q[i]   <= pos_d[i];
                step_q[i]  <= step_d[i];
                last_q[i]  <= last_d[i];
            end
        end
    end

endmodule
